isolator_shift_reader: RTL

- Downstream consumer of the 74165-style parallel-in/serial-out chain on the isolator PCB.
- Drives the chain's active-low load strobe (clk_par) and its shift clock (clk_ser), samples the chain's serial output (data_ser) and reassembles NUM_BYTES bytes into one parallel word.
- Presents the word to the DSD1792 test logic over a valid/ready handshake.

---
 rtl/isolator_pkg.sv | 33 +++
 rtl/isolator_phase_timer.sv | 40 ++++
 rtl/isolator_shift_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/isolator_pkg.sv
// Shared types and helpers for the isolator shift-chain reader.
// Holds the FSM encoding, word width and transaction length.
package isolator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    DELIVER
  } state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  function automatic int unsigned word_w(
    input int unsigned nb
  );
    return BITS_PER_BYTE * nb;
  endfunction

  localparam int unsigned DEF_NUM_BYTES = 1;
  localparam int unsigned DEF_WORD_W = word_w(DEF_NUM_BYTES);

  // Cycle index of DELIVER when start is accepted at cycle 0.
  function automatic int unsigned xact_len(
    input int unsigned nb,
    input int unsigned div
  );
    return 1 + div * (2 + 16 * nb);
  endfunction

endpackage

// File: rtl/isolator_phase_timer.sv
// Per-phase down-counter for the shift reader.
// Reloads on every state entry and flags the last cycle of a phase.
module isolator_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load_i,
  output logic last_o
);

  localparam int unsigned CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload on entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TOP;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= TOP;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/isolator_shift_reader.sv
// Reads a 74165-style PISO chain and hands the word downstream.
// Strobes, busy, word and overrun are all registered outputs.
module isolator_shift_reader
  import isolator_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 1,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   clk_par,
  output logic                   clk_ser,
  input  logic                   data_ser,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   overrun
);

  localparam int unsigned W = word_w(NUM_BYTES);
  localparam int unsigned BCW = $clog2(W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

  state_e         state_q, state_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, par_q, ser_q;
  logic           last;
  logic           tload;

  assign tload = (state_d != state_q) || (state_q == IDLE);

  isolator_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .load_i   (tload),
    .last_o   (last)
  );

  // Phase sequencing, bit counting and serial capture.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (last) state_d = SETTLE;
      end
      SETTLE: begin
        bit_d = '0;
        if (last) state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (last) begin
          acc_d   = {acc_q[W-2:0], data_ser};
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (last) begin
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == LAST_BIT) ? DELIVER
                                        : SHIFT_LO;
        end
      end
      DELIVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output word handshake; a busy consumer drops the new word.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (state_q == DELIVER) begin
      if (!valid_q || data_ready) begin
        dout_d  = acc_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and registered outputs, strobes decoded from next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      par_q   <= 1'b1;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
      par_q   <= (state_d != LOAD);
      ser_q   <= (state_d == SHIFT_HI);
    end
  end

  assign busy       = busy_q;
  assign clk_par    = par_q;
  assign clk_ser    = ser_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule
